// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: pc, single-outstanding request, skid buffer, redirect discard
// Optional direct-mapped BTB enabled by defining FETCH_BTB_EN.
module fetch #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] NOP_INSTR    = 64'h0,
  parameter int          BTB_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [63:0] redirect_pc_in,
  input  logic        btb_update_in,
  input  logic [63:0] btb_update_pc_in,
  input  logic [63:0] btb_update_target_in,
  input  logic        btb_update_taken_in,
  output logic        instr_read_out,
  output logic [63:0] instr_address_out,
  input  logic        instr_ready_in,
  input  logic [63:0] instr_read_value_in,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [63:0] instr_out,
  output logic        branch_predicted_taken_out
);

  typedef enum logic [1:0] {S_REQ, S_BUFFERED, S_DISCARD} state_t;

  state_t      state;
  logic [63:0] pc_reg;
  logic [63:0] held_addr;
  logic [63:0] skid_pc;
  logic [63:0] skid_instr;
  logic        skid_pred;
  logic        pred;
  logic [63:0] next_pc;
  logic [63:0] redirect_pc;

  assign redirect_pc = {redirect_pc_in[63:3], 3'b000};

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 64 - 3 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [63:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_cnt    [BTB_ENTRIES];
  logic [IDX_W-1:0]       lk_idx;
  logic [IDX_W-1:0]       up_idx;
  logic [TAG_W-1:0]       up_tag;
  logic                   up_hit;
  logic                   unused_low_bits;

  assign lk_idx  = pc_reg[3 +: IDX_W];
  assign up_idx  = btb_update_pc_in[3 +: IDX_W];
  assign up_tag  = btb_update_pc_in[63 -: TAG_W];
  assign up_hit  = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  assign pred    = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc_reg[63 -: TAG_W]) && btb_cnt[lk_idx][1];
  assign next_pc = pred ? btb_target[lk_idx] : pc_reg + 64'd8;
  assign unused_low_bits = ^{btb_update_pc_in[2:0], redirect_pc_in[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btb_valid <= '0;
    end else if (btb_update_in && !up_hit && btb_update_taken_in) begin
      btb_valid[up_idx] <= 1'b1;
    end
  end

  // Lookups read these registers, so a same-cycle update is seen only from the next edge.
  always_ff @(posedge clk) begin
    if (btb_update_in) begin
      if (up_hit) begin
        if (btb_update_taken_in) begin
          btb_target[up_idx] <= btb_update_target_in;
          if (btb_cnt[up_idx] != 2'b11) btb_cnt[up_idx] <= btb_cnt[up_idx] + 2'd1;
        end else if (btb_cnt[up_idx] != 2'b00) begin
          btb_cnt[up_idx] <= btb_cnt[up_idx] - 2'd1;
        end
      end else if (btb_update_taken_in) begin
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= btb_update_target_in;
        btb_cnt[up_idx]    <= 2'b10;
      end
    end
  end
`else
  logic unused_inputs;

  assign pred    = 1'b0;
  assign next_pc = pc_reg + 64'd8;
  assign unused_inputs = ^{btb_update_in, btb_update_pc_in, btb_update_target_in,
                           btb_update_taken_in, redirect_pc_in[2:0]};
`endif

  assign instr_read_out    = (state != S_BUFFERED);
  assign instr_address_out = (state == S_DISCARD) ? held_addr : pc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= S_REQ;
      pc_reg                     <= RESET_VECTOR;
      held_addr                  <= '0;
      skid_pc                    <= '0;
      skid_instr                 <= NOP_INSTR;
      skid_pred                  <= 1'b0;
      valid_out                  <= 1'b0;
      pc_out                     <= '0;
      instr_out                  <= NOP_INSTR;
      branch_predicted_taken_out <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_in) begin
            pc_reg    <= redirect_pc;
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
            if (!instr_ready_in) begin
              held_addr <= pc_reg;
              state     <= S_DISCARD;
            end
          end else if (instr_ready_in) begin
            pc_reg <= next_pc;
            if (!stall_in) begin
              valid_out                  <= 1'b1;
              pc_out                     <= pc_reg;
              instr_out                  <= instr_read_value_in;
              branch_predicted_taken_out <= pred;
            end else begin
              skid_pc    <= pc_reg;
              skid_instr <= instr_read_value_in;
              skid_pred  <= pred;
              state      <= S_BUFFERED;
            end
          end else if (!stall_in) begin
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
          end
        end
        S_BUFFERED: begin
          if (redirect_in) begin
            pc_reg    <= redirect_pc;
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
            state     <= S_REQ;
          end else if (!stall_in) begin
            valid_out                  <= 1'b1;
            pc_out                     <= skid_pc;
            instr_out                  <= skid_instr;
            branch_predicted_taken_out <= skid_pred;
            state                      <= S_REQ;
          end
        end
        S_DISCARD: begin
          // The abandoned request must still complete before a new address may be issued.
          if (redirect_in) pc_reg <= redirect_pc;
          if (instr_ready_in) state <= S_REQ;
          if (redirect_in || !stall_in) begin
            valid_out <= 1'b0;
            instr_out <= NOP_INSTR;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch
module tb_fetch;

  localparam logic [63:0] NOP = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [63:0] redirect_pc_in = '0;
  logic        btb_update_in = 1'b0;
  logic [63:0] btb_update_pc_in = '0;
  logic [63:0] btb_update_target_in = '0;
  logic        btb_update_taken_in = 1'b0;
  logic        instr_read_out;
  logic [63:0] instr_address_out;
  logic        instr_ready_in = 1'b1;
  logic [63:0] instr_read_value_in;
  logic        valid_out;
  logic [63:0] pc_out;
  logic [63:0] instr_out;
  logic        branch_predicted_taken_out;

  int tests = 0;
  int fails = 0;

  fetch dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .stall_in                   (stall_in),
    .redirect_in                (redirect_in),
    .redirect_pc_in             (redirect_pc_in),
    .btb_update_in              (btb_update_in),
    .btb_update_pc_in           (btb_update_pc_in),
    .btb_update_target_in       (btb_update_target_in),
    .btb_update_taken_in        (btb_update_taken_in),
    .instr_read_out             (instr_read_out),
    .instr_address_out          (instr_address_out),
    .instr_ready_in             (instr_ready_in),
    .instr_read_value_in        (instr_read_value_in),
    .valid_out                  (valid_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out),
    .branch_predicted_taken_out (branch_predicted_taken_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return a ^ 64'hDEAD_BEEF_0000_0000;
  endfunction

  assign instr_read_value_in = mem_data(instr_address_out);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic rd, input logic [63:0] addr);
    chk({tag, ".read"}, {63'd0, instr_read_out}, {63'd0, rd});
    chk({tag, ".addr"}, instr_address_out, addr);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] pc);
    chk({tag, ".valid"}, {63'd0, valid_out}, {63'd0, v});
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".instr"}, instr_out, v ? mem_data(pc) : NOP);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk_out("reset", 1'b0, 64'h0);
    chk("reset.pred", {63'd0, branch_predicted_taken_out}, 64'd0);
    chk_req("reset", 1'b1, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Zero-wait streaming from the reset vector.
    tick(); chk_out("seq0", 1'b1, 64'h00); chk_req("seq0", 1'b1, 64'h08);
    tick(); chk_out("seq1", 1'b1, 64'h08); chk_req("seq1", 1'b1, 64'h10);
    tick(); chk_out("seq2", 1'b1, 64'h10); chk_req("seq2", 1'b1, 64'h18);
    tick(); chk_out("seq3", 1'b1, 64'h18); chk_req("seq3", 1'b1, 64'h20);

    // Three wait states at 0x20.
    instr_ready_in = 1'b0;
    tick(); chk("ws0.valid", {63'd0, valid_out}, 64'd0); chk_req("ws0", 1'b1, 64'h20);
    tick(); chk("ws1.valid", {63'd0, valid_out}, 64'd0); chk_req("ws1", 1'b1, 64'h20);
    tick(); chk_out("ws2", 1'b0, 64'h18); chk_req("ws2", 1'b1, 64'h20);
    instr_ready_in = 1'b1;
    tick(); chk_out("ws_done", 1'b1, 64'h20); chk_req("ws_done", 1'b1, 64'h28);
    tick(); tick(); tick();
    chk_out("pre_stall", 1'b1, 64'h38); chk_req("pre_stall", 1'b1, 64'h40);

    // Stall when 0x40 data returns: skid captures it.
    stall_in = 1'b1;
    tick(); chk_out("stall0", 1'b1, 64'h38); chk_req("stall0", 1'b0, 64'h48);
    tick(); chk_out("stall1", 1'b1, 64'h38); chk_req("stall1", 1'b0, 64'h48);
    stall_in = 1'b0;
    tick(); chk_out("unstall", 1'b1, 64'h40); chk_req("unstall", 1'b1, 64'h48);
    tick(); chk_out("post_stall", 1'b1, 64'h48); chk_req("post_stall", 1'b1, 64'h50);

    // Redirect while 0x50 is pending: address held, data dropped.
    instr_ready_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 64'h1003;
    tick(); chk("rd0.valid", {63'd0, valid_out}, 64'd0); chk_req("rd0", 1'b1, 64'h50);
    redirect_in = 1'b0;
    tick(); chk("rd1.valid", {63'd0, valid_out}, 64'd0); chk_req("rd1", 1'b1, 64'h50);
    instr_ready_in = 1'b1;
    tick(); chk("rd2.valid", {63'd0, valid_out}, 64'd0); chk_req("rd2", 1'b1, 64'h1000);
    tick(); chk_out("rd3", 1'b1, 64'h1000); chk_req("rd3", 1'b1, 64'h1008);

    // Zero-wait redirect latency: target address at N+1, target instruction at N+2.
    redirect_in = 1'b1; redirect_pc_in = 64'h2000;
    tick(); chk_out("lat1", 1'b0, 64'h1000); chk_req("lat1", 1'b1, 64'h2000);
    redirect_in = 1'b0;
    tick(); chk_out("lat2", 1'b1, 64'h2000); chk_req("lat2", 1'b1, 64'h2008);

    // Redirect plus stall while buffered: skid is dropped.
    stall_in = 1'b1;
    tick(); chk_out("buf", 1'b1, 64'h2000); chk_req("buf", 1'b0, 64'h2010);
    redirect_in = 1'b1; redirect_pc_in = 64'h3000;
    tick(); chk("rs.valid", {63'd0, valid_out}, 64'd0); chk_req("rs", 1'b1, 64'h3000);
    redirect_in = 1'b0; stall_in = 1'b0;
    tick(); chk_out("rs_after", 1'b1, 64'h3000); chk_req("rs_after", 1'b1, 64'h3008);

    // Redirect plus stall in REQ with data ready.
    stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 64'h4000;
    tick(); chk("rs2.valid", {63'd0, valid_out}, 64'd0); chk_req("rs2", 1'b1, 64'h4000);
    redirect_in = 1'b0; stall_in = 1'b0;
    tick(); chk_out("rs2_after", 1'b1, 64'h4000);

    // PC wraps modulo 2^64.
    redirect_in = 1'b1; redirect_pc_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); chk_req("wrap0", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    redirect_in = 1'b0;
    tick(); chk_out("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8); chk_req("wrap1", 1'b1, 64'h0);

    // BTB: taken update then fetch 0x100.
    btb_update_in = 1'b1; btb_update_pc_in = 64'h100;
    btb_update_target_in = 64'h400; btb_update_taken_in = 1'b1;
    redirect_in = 1'b1; redirect_pc_in = 64'h100;
    tick();
    btb_update_in = 1'b0; redirect_in = 1'b0;
    chk_req("btb0", 1'b1, 64'h100);
    tick();
    chk_out("btb1", 1'b1, 64'h100);
`ifdef FETCH_BTB_EN
    chk("btb1.pred", {63'd0, branch_predicted_taken_out}, 64'd1);
    chk_req("btb1", 1'b1, 64'h400);
`else
    chk("btb1.pred", {63'd0, branch_predicted_taken_out}, 64'd0);
    chk_req("btb1", 1'b1, 64'h108);
`endif
    btb_update_in = 1'b1; btb_update_taken_in = 1'b0;
    tick(); tick();
    btb_update_in = 1'b0;
    redirect_in = 1'b1; redirect_pc_in = 64'h100;
    tick();
    redirect_in = 1'b0;
    tick();
    chk_out("btb2", 1'b1, 64'h100);
    chk("btb2.pred", {63'd0, branch_predicted_taken_out}, 64'd0);
    chk_req("btb2", 1'b1, 64'h108);

    // Async reset mid-request.
    instr_ready_in = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk_out("areset", 1'b0, 64'h0); chk_req("areset", 1'b1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
